// File: rtl/sw_pkg.sv
// Shared constants for the switch conditioner and the LSU switch port.
`ifndef VECTOR_RANGE
`define VECTOR_RANGE 31:0
`endif

package sw_pkg;
  localparam int IO_SW_W        = 32;
  localparam int NUM_SW_DEFAULT = 18;
endpackage

// File: rtl/sw_debounce_bit.sv
// One switch bit: 2-flop synchroniser, tick-driven debounce counter and
// registered rise/fall pulses that coincide with the level change.
module sw_debounce_bit #(
  parameter int STABLE_TICKS = 10
) (
  input  logic clk,
  input  logic rst_n,
  input  logic tick,
  input  logic raw,
  output logic level,
  output logic rise,
  output logic fall
);
  localparam int CW = $clog2(STABLE_TICKS + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(STABLE_TICKS - 1);

  logic          s1;
  logic          s2;
  logic [CW-1:0] cnt;
  logic          accept;

  function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
    return (v == CNT_LAST) ? CNT_LAST : v + CW'(1);
  endfunction

  assign accept = (s2 != level) && tick && (cnt == CNT_LAST);

  // Synchroniser stage: s1 then s2, no logic in between.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
    end else begin
      s1 <= raw;
      s2 <= s1;
    end
  end

  // Debounce stage: any cycle that agrees with the accepted level discards progress.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      level <= 1'b0;
      cnt   <= '0;
      rise  <= 1'b0;
      fall  <= 1'b0;
    end else begin
      rise <= accept && s2;
      fall <= accept && !s2;
      if (s2 == level) begin
        cnt <= '0;
      end else if (accept) begin
        level <= s2;
        cnt   <= '0;
      end else if (tick) begin
        cnt <= sat_inc(cnt);
      end
    end
  end
endmodule

// File: rtl/sw_conditioner.sv
// Slide-switch conditioner: shared sample prescaler, per-bit debouncers and
// zero-extension onto the 32-bit LSU switch port.
module sw_conditioner
  import sw_pkg::*;
#(
  parameter int NUM_SW       = NUM_SW_DEFAULT,
  parameter int TICK_DIV     = 50000,
  parameter int STABLE_TICKS = 10
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic [NUM_SW-1:0]   sw_raw_i,
  output logic [`VECTOR_RANGE] io_sw_o,
  output logic [NUM_SW-1:0]   sw_rise_o,
  output logic [NUM_SW-1:0]   sw_fall_o
);
  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] PRE_LAST = PW'(TICK_DIV - 1);

  logic [PW-1:0]     pre_cnt;
  logic              tick;
  logic [NUM_SW-1:0] stable;

  // With TICK_DIV=1 the counter sits at 0 and tick is permanently high.
  assign tick = (pre_cnt == PRE_LAST);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      pre_cnt <= '0;
    end else begin
      pre_cnt <= tick ? '0 : pre_cnt + PW'(1);
    end
  end

  for (genvar i = 0; i < NUM_SW; i++) begin : g_bit
    sw_debounce_bit #(
      .STABLE_TICKS(STABLE_TICKS)
    ) u_bit (
      .clk  (clk_i),
      .rst_n(rst_ni),
      .tick (tick),
      .raw  (sw_raw_i[i]),
      .level(stable[i]),
      .rise (sw_rise_o[i]),
      .fall (sw_fall_o[i])
    );
  end

  assign io_sw_o = IO_SW_W'(stable);
endmodule

// File: tb/tb_sw_conditioner.sv
// Bench for sw_conditioner: two instances (fast tick / prescaled tick) checked
// every cycle against a sample-history reference model plus directed scenarios.
module tb_sw_conditioner;
  localparam int TD [2] = '{1, 4};
  localparam int ST [2] = '{3, 2};

  logic        clk   = 1'b0;
  logic        rst_n = 1'b1;
  logic [17:0] ra    = '0;
  logic [17:0] rb    = '0;
  logic [31:0] io_a, io_b;
  logic [17:0] rise_a, fall_a, rise_b, fall_b;

  int errs   = 0;
  int checks = 0;

  always #5 clk = ~clk;

  sw_conditioner #(.NUM_SW(18), .TICK_DIV(1), .STABLE_TICKS(3)) dut_a (
    .clk_i(clk), .rst_ni(rst_n), .sw_raw_i(ra),
    .io_sw_o(io_a), .sw_rise_o(rise_a), .sw_fall_o(fall_a));

  sw_conditioner #(.NUM_SW(18), .TICK_DIV(4), .STABLE_TICKS(2)) dut_b (
    .clk_i(clk), .rst_ni(rst_n), .sw_raw_i(rb),
    .io_sw_o(io_b), .sw_rise_o(rise_b), .sw_fall_o(fall_b));

  // Reference model: raw samples per edge, run of mismatching ticks per bit.
  logic [17:0] hist   [2][$];
  logic [17:0] m_lvl  [2];
  logic [17:0] m_rise [2];
  logic [17:0] m_fall [2];
  int          m_run  [2][18];
  int          m_edges[2];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      hist[d].delete();
      m_lvl[d]   = '0;
      m_rise[d]  = '0;
      m_fall[d]  = '0;
      m_edges[d] = 0;
      for (int i = 0; i < 18; i++) m_run[d][i] = 0;
    end
  endtask

  task automatic model_edge(input int d, input logic [17:0] raw);
    logic [17:0] synced;
    bit          tk;
    synced = (hist[d].size() >= 2) ? hist[d][hist[d].size() - 2] : 18'h0;
    hist[d].push_back(raw);
    tk = ((m_edges[d] % TD[d]) == TD[d] - 1);
    m_edges[d]++;
    m_rise[d] = '0;
    m_fall[d] = '0;
    for (int i = 0; i < 18; i++) begin
      if (synced[i] == m_lvl[d][i]) begin
        m_run[d][i] = 0;
      end else if (tk) begin
        m_run[d][i]++;
        if (m_run[d][i] == ST[d]) begin
          m_lvl[d][i] = synced[i];
          m_run[d][i] = 0;
          if (synced[i]) m_rise[d][i] = 1'b1;
          else           m_fall[d][i] = 1'b1;
        end
      end
    end
  endtask

  task automatic step();
    @(posedge clk);
    if (rst_n) begin
      model_edge(0, ra);
      model_edge(1, rb);
    end
    #1;
    check("a_level", io_a, {14'd0, m_lvl[0]});
    check("a_rise", {14'd0, rise_a}, {14'd0, m_rise[0]});
    check("a_fall", {14'd0, fall_a}, {14'd0, m_fall[0]});
    check("b_level", io_b, {14'd0, m_lvl[1]});
    check("b_rise", {14'd0, rise_b}, {14'd0, m_rise[1]});
    check("b_fall", {14'd0, fall_b}, {14'd0, m_fall[1]});
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_io_a"}, io_a, 32'h0);
    check({tag, "_io_b"}, io_b, 32'h0);
    check({tag, "_pulses"}, {14'd0, rise_a | fall_a | rise_b | fall_b}, 32'h0);
  endtask

  initial begin
    logic [17:0] acc;
    int          lat;
    model_reset();
    ra = 18'h3FFFF;
    #2 rst_n = 1'b0;
    #1 check_all_zero("rst_noclk");
    repeat (3) step();

    // Release with all switches high: level appears 5 edges later.
    rst_n = 1'b1;
    for (int k = 1; k <= 6; k++) begin
      step();
      if (k == 4) check("rel_e4_level", io_a, 32'h0);
      if (k == 5) begin
        check("rel_e5_level", io_a, 32'h0003_FFFF);
        check("rel_e5_rise", {14'd0, rise_a}, 32'h0003_FFFF);
      end
      if (k == 6) check("rel_e6_rise", {14'd0, rise_a}, 32'h0);
    end

    ra = '0;
    for (int k = 1; k <= 6; k++) begin
      step();
      if (k == 5) check("all_fall", {14'd0, fall_a}, 32'h0003_FFFF);
    end

    // Clean change on bit 0.
    ra = 18'h00001;
    for (int k = 1; k <= 6; k++) begin
      step();
      if (k == 4) check("clean_e4", io_a, 32'h0);
      if (k == 5) begin
        check("clean_e5", io_a, 32'h1);
        check("clean_rise", {14'd0, rise_a}, 32'h1);
      end
      if (k == 6) check("clean_rise_end", {14'd0, rise_a}, 32'h0);
    end

    // Two-cycle glitch on bit 3.
    acc = '0;
    ra[3] = 1'b1;
    repeat (2) begin step(); acc |= rise_a | fall_a; end
    ra[3] = 1'b0;
    repeat (8) begin step(); acc |= rise_a | fall_a; end
    check("glitch_level", io_a, 32'h1);
    check("glitch_pulses", {14'd0, acc}, 32'h0);

    // Bounce on bit 5: 1,0,1,0 then final 1 held.
    for (int k = 0; k < 4; k++) begin
      ra[5] = (k % 2 == 0);
      step();
    end
    ra[5] = 1'b1;
    acc = '0;
    for (int k = 1; k <= 8; k++) begin
      step();
      acc |= rise_a;
      if (k == 4) check("bounce_e4", io_a, 32'h1);
      if (k == 5) check("bounce_e5", io_a, 32'h21);
    end
    check("bounce_rise", {14'd0, acc}, 32'h20);

    // Prescaled instance: latency between 2+4 and 2+8 edges.
    rb[0] = 1'b1;
    lat = 0;
    for (int k = 1; k <= 20; k++) begin
      step();
      if (lat == 0 && io_b[0]) lat = k;
    end
    check("pre_latency_in_range", {31'd0, (lat >= 6 && lat <= 10)}, 32'h1);

    // Five-cycle glitch, started so its window holds only one tick.
    for (int k = 0; k < 4 && (m_edges[1] % 4) != 0; k++) step();
    acc = '0;
    rb[1] = 1'b1;
    repeat (5) begin step(); acc |= rise_b | fall_b; end
    rb[1] = 1'b0;
    repeat (12) begin step(); acc |= rise_b | fall_b; end
    check("pre_glitch_level", {31'd0, io_b[1]}, 32'h0);
    check("pre_glitch_pulses", {31'd0, acc[1]}, 32'h0);

    // Mid-debounce reset with bit 7 part-way through its count.
    ra[7] = 1'b1;
    repeat (4) step();
    #1 rst_n = 1'b0;
    model_reset();
    #1 check_all_zero("mid_rst");
    repeat (2) step();
    rst_n = 1'b1;
    for (int k = 1; k <= 5; k++) begin
      step();
      if (k == 4) check("mid_rel_e4", io_a, 32'h0);
      if (k == 5) begin
        check("mid_rel_e5", io_a, 32'hA1);
        check("mid_rel_rise", {14'd0, rise_a}, 32'hA1);
      end
    end
    ra[7] = 1'b0;
    for (int k = 1; k <= 6; k++) begin
      step();
      if (k == 4) check("fall7_e4", io_a, 32'hA1);
      if (k == 5) begin
        check("fall7_e5", io_a, 32'h21);
        check("fall7_pulse", {14'd0, fall_a}, 32'h80);
        check("fall7_no_rise", {14'd0, rise_a}, 32'h0);
      end
    end

    // Random activity on both instances, with one reset in the middle.
    for (int n = 0; n < 600; n++) begin
      ra ^= 18'($urandom & $urandom & $urandom & $urandom);
      rb ^= 18'($urandom & $urandom & $urandom & $urandom & $urandom & $urandom);
      step();
      if (n == 300) begin
        rst_n = 1'b0;
        model_reset();
        #1 check_all_zero("rand_rst");
        step();
        rst_n = 1'b1;
      end
    end

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
